// File: rtl/pin_cracker_pkg.sv
// Shared types and constants for the PIN brute-force cracker.
package pin_cracker_pkg;

   typedef enum logic [2:0] {
      IDLE,
      RESET_SAFE,
      SEND,
      GAP,
      CHECK,
      DONE,
      FAIL
   } state_t;

   localparam int PIN_LEN_DEFAULT = 4;
   localparam int ATTEMPT_CNT_W   = 32;

endpackage

// File: rtl/pin_serializer.sv
// Emits one candidate MSB byte first, PIN_LEN strobes spaced by GAP_CYCLES idle cycles.
module pin_serializer
   import pin_cracker_pkg::*;
#(
   parameter int PIN_LEN    = PIN_LEN_DEFAULT,
   parameter int GAP_CYCLES = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load,
   input  logic [8*PIN_LEN-1:0] candidate,
   output logic [7:0]           byte_out,
   output logic                 byte_valid,
   output logic                 done,
   output logic                 last_gap
);

   localparam int CODE_W = 8 * PIN_LEN;
   localparam int IDX_W  = (PIN_LEN > 1) ? $clog2(PIN_LEN) : 1;
   localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIN_LEN - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

   logic [CODE_W-1:0] shreg;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  idx_nxt;
   logic [GAP_W-1:0]  gap_cnt;
   logic              in_gap;

   assign idx_nxt  = idx + 1'b1;
   assign last_gap = in_gap && (gap_cnt == '0);

   // shreg is pure data and is always reloaded before use, so it carries no reset
   always_ff @(posedge clk) begin
      if (load) begin
         shreg <= candidate << 8;
      end else if ((byte_valid && !done && GAP_CYCLES == 0) || last_gap) begin
         shreg <= shreg << 8;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         idx        <= '0;
         gap_cnt    <= '0;
         in_gap     <= 1'b0;
         byte_out   <= '0;
         byte_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         byte_out   <= '0;
         byte_valid <= 1'b0;
         done       <= 1'b0;
         if (load) begin
            byte_out   <= candidate[CODE_W-1 -: 8];
            byte_valid <= 1'b1;
            idx        <= '0;
            in_gap     <= 1'b0;
            done       <= (PIN_LEN == 1);
         end else if ((byte_valid && !done && GAP_CYCLES == 0) || last_gap) begin
            byte_out   <= shreg[CODE_W-1 -: 8];
            byte_valid <= 1'b1;
            idx        <= idx_nxt;
            in_gap     <= 1'b0;
            done       <= (idx_nxt == IDX_LAST);
         end else if (byte_valid && !done) begin
            in_gap  <= 1'b1;
            gap_cnt <= GAP_LAST;
         end else if (in_gap) begin
            gap_cnt <= gap_cnt - 1'b1;
         end
      end
   end

endmodule

// File: rtl/pin_cracker.sv
// Brute-force PIN cracker driving a safe lock's din/din_valid interface.
// Define PIN_CRACKER_SVA_EN to embed protocol assertions and covers.
module pin_cracker
   import pin_cracker_pkg::*;
#(
   parameter int PIN_LEN       = PIN_LEN_DEFAULT,
   parameter int GAP_CYCLES    = 0,
   parameter int SETTLE_CYCLES = 1
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [8*PIN_LEN-1:0]     seed,
   output logic [7:0]               safe_din,
   output logic                     safe_din_valid,
   output logic                     safe_reset,
   input  logic                     safe_unlocked,
   output logic                     busy,
   output logic                     found,
   output logic                     exhausted,
   output logic [8*PIN_LEN-1:0]     code,
   output logic [ATTEMPT_CNT_W-1:0] attempts
);

   localparam int CODE_W   = 8 * PIN_LEN;
   localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [SETTLE_W-1:0] SETTLE_LAST =
      SETTLE_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

   state_t                state;
   logic [CODE_W-1:0]     candidate;
   logic [SETTLE_W-1:0]   settle_cnt;
   logic                  ser_done;
   logic                  ser_last_gap;

   pin_serializer #(
      .PIN_LEN    (PIN_LEN),
      .GAP_CYCLES (GAP_CYCLES)
   ) u_serializer (
      .clk        (clk),
      .reset      (reset),
      .load       (state == RESET_SAFE),
      .candidate  (candidate),
      .byte_out   (safe_din),
      .byte_valid (safe_din_valid),
      .done       (ser_done),
      .last_gap   (ser_last_gap)
   );

   // safe_reset and busy are registered alongside the state they belong to
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         candidate  <= '0;
         settle_cnt <= '0;
         attempts   <= '0;
         found      <= 1'b0;
         exhausted  <= 1'b0;
         code       <= '0;
         safe_reset <= 1'b0;
         busy       <= 1'b0;
      end else begin
         safe_reset <= 1'b0;
         case (state)
            IDLE, DONE, FAIL: begin
               if (start) begin
                  candidate  <= seed;
                  attempts   <= '0;
                  found      <= 1'b0;
                  exhausted  <= 1'b0;
                  code       <= '0;
                  safe_reset <= 1'b1;
                  busy       <= 1'b1;
                  state      <= RESET_SAFE;
               end
            end
            RESET_SAFE: state <= SEND;
            SEND: begin
               if (ser_done) begin
                  settle_cnt <= SETTLE_LAST;
                  state      <= CHECK;
               end else if (GAP_CYCLES > 0) begin
                  state <= GAP;
               end
            end
            GAP: begin
               if (ser_last_gap) state <= SEND;
            end
            CHECK: begin
               if (settle_cnt == '0) begin
                  if (attempts != {ATTEMPT_CNT_W{1'b1}}) attempts <= attempts + 1'b1;
                  if (safe_unlocked) begin
                     code  <= candidate;
                     found <= 1'b1;
                     busy  <= 1'b0;
                     state <= DONE;
                  end else if (&candidate) begin
                     exhausted <= 1'b1;
                     busy      <= 1'b0;
                     state     <= FAIL;
                  end else begin
                     candidate  <= candidate + 1'b1;
                     safe_reset <= 1'b1;
                     state      <= RESET_SAFE;
                  end
               end else begin
                  settle_cnt <= settle_cnt - 1'b1;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

`ifdef PIN_CRACKER_SVA_EN
   int sva_strobes;

   always_ff @(posedge clk) begin
      if (reset || safe_reset) sva_strobes <= 0;
      else if (safe_din_valid) sva_strobes <= sva_strobes + 1;
   end

   a_no_reset_with_strobe: assert property (@(posedge clk) disable iff (reset)
      !(safe_reset && safe_din_valid));
   a_found_after_unlock: assert property (@(posedge clk) disable iff (reset)
      $rose(found) |-> $past(safe_unlocked));
   a_burst_not_too_long: assert property (@(posedge clk) disable iff (reset)
      safe_din_valid |-> (sva_strobes < PIN_LEN));
   a_burst_complete: assert property (@(posedge clk) disable iff (reset)
      (state == CHECK) |-> (sva_strobes == PIN_LEN));
   a_attempts_monotonic: assert property (@(posedge clk) disable iff (reset)
      (busy && $past(busy)) |-> (attempts >= $past(attempts)));
   c_found: cover property (@(posedge clk) disable iff (reset) found);
   c_exhausted: cover property (@(posedge clk) disable iff (reset) exhausted);
`endif

endmodule

// File: tb/tb_pin_cracker.sv
// Directed bench for pin_cracker against a behavioural 4-byte lock model.
module tb_pin_cracker;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] lock_code = 32'hBAADC0DE;

   // default-parameter DUT
   logic        start = 1'b0;
   logic [31:0] seed = '0;
   logic [7:0]  safe_din;
   logic        safe_din_valid, safe_reset, safe_unlocked;
   logic        busy, found, exhausted;
   logic [31:0] code, attempts;

   // GAP_CYCLES=2 DUT
   logic        start_g = 1'b0;
   logic [31:0] seed_g = '0;
   logic [7:0]  safe_din_g;
   logic        safe_din_valid_g, safe_reset_g, safe_unlocked_g;
   logic        busy_g, found_g, exhausted_g;
   logic [31:0] code_g, attempts_g;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   pin_cracker dut (
      .clk(clk), .reset(reset), .start(start), .seed(seed),
      .safe_din(safe_din), .safe_din_valid(safe_din_valid), .safe_reset(safe_reset),
      .safe_unlocked(safe_unlocked), .busy(busy), .found(found), .exhausted(exhausted),
      .code(code), .attempts(attempts)
   );

   pin_cracker #(.GAP_CYCLES(2)) dut_g (
      .clk(clk), .reset(reset), .start(start_g), .seed(seed_g),
      .safe_din(safe_din_g), .safe_din_valid(safe_din_valid_g), .safe_reset(safe_reset_g),
      .safe_unlocked(safe_unlocked_g), .busy(busy_g), .found(found_g), .exhausted(exhausted_g),
      .code(code_g), .attempts(attempts_g)
   );

   // lock models: unlock after exactly four bytes matching lock_code
   logic [31:0] lk_sh, lk_sh_g;
   logic [2:0]  lk_cnt, lk_cnt_g;

   always_ff @(posedge clk) begin
      if (reset || safe_reset) begin
         lk_sh <= '0; lk_cnt <= '0; safe_unlocked <= 1'b0;
      end else if (safe_din_valid) begin
         lk_sh  <= {lk_sh[23:0], safe_din};
         lk_cnt <= lk_cnt + 3'd1;
         if (lk_cnt == 3'd3) safe_unlocked <= ({lk_sh[23:0], safe_din} == lock_code);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || safe_reset_g) begin
         lk_sh_g <= '0; lk_cnt_g <= '0; safe_unlocked_g <= 1'b0;
      end else if (safe_din_valid_g) begin
         lk_sh_g  <= {lk_sh_g[23:0], safe_din_g};
         lk_cnt_g <= lk_cnt_g + 3'd1;
         if (lk_cnt_g == 3'd3) safe_unlocked_g <= ({lk_sh_g[23:0], safe_din_g} == lock_code);
      end
   end

   // leaves the bench in cycle 1 after the accepting edge
   task automatic start_pulse(input logic [31:0] s);
      @(negedge clk); seed = s; start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      total++; if ({safe_din_valid, safe_reset, safe_din} !== 10'h0)
         $display("FAIL reset_safe_if got=%h exp=0", {safe_din_valid, safe_reset, safe_din}); else passed++;
      total++; if ({busy, found, exhausted} !== 3'b000)
         $display("FAIL reset_flags got=%b exp=000", {busy, found, exhausted}); else passed++;
      total++; if ({code, attempts} !== 64'h0)
         $display("FAIL reset_code_attempts got=%h exp=0", {code, attempts}); else passed++;
   endtask

   task automatic test_first_hit();
      int n;
      lock_code = 32'hBAADC0DE;
      start_pulse(32'hBAADC0DE);
      n = 1;
      total++; if ({busy, safe_reset, safe_din_valid} !== 3'b110)
         $display("FAIL hit_cycle1 got=%b exp=110", {busy, safe_reset, safe_din_valid}); else passed++;
      while (!found && n < 40) begin @(negedge clk); n++; end
      total++; if (n !== 7) $display("FAIL hit_latency got=%0d exp=7", n); else passed++;
      total++; if (code !== 32'hBAADC0DE) $display("FAIL hit_code got=%h exp=baadc0de", code); else passed++;
      total++; if (attempts !== 32'd1) $display("FAIL hit_attempts got=%0d exp=1", attempts); else passed++;
      total++; if ({busy, exhausted} !== 2'b00)
         $display("FAIL hit_busy_exh got=%b exp=00", {busy, exhausted}); else passed++;
   endtask

   task automatic test_search();
      int n, resets;
      start_pulse(32'hBAADC0DC);
      n = 1; resets = int'(safe_reset);
      while (!found && n < 100) begin @(negedge clk); n++; resets += int'(safe_reset); end
      total++; if (n !== 19) $display("FAIL search_latency got=%0d exp=19", n); else passed++;
      total++; if (attempts !== 32'd3) $display("FAIL search_attempts got=%0d exp=3", attempts); else passed++;
      total++; if (resets !== 3) $display("FAIL search_resets got=%0d exp=3", resets); else passed++;
      total++; if (code !== 32'hBAADC0DE) $display("FAIL search_code got=%h exp=baadc0de", code); else passed++;
   endtask

   task automatic test_exhaust();
      int n, resets;
      lock_code = 32'h12345678;
      start_pulse(32'hFFFF_FFFE);
      n = 1;
      while (!exhausted && n < 100) begin @(negedge clk); n++; end
      total++; if (n !== 13) $display("FAIL exh_latency got=%0d exp=13", n); else passed++;
      total++; if (attempts !== 32'd2) $display("FAIL exh_attempts got=%0d exp=2", attempts); else passed++;
      total++; if ({found, busy, code} !== 34'h0)
         $display("FAIL exh_found_busy_code got=%h exp=0", {found, busy, code}); else passed++;
      resets = 0;
      for (int i = 0; i < 10; i++) begin @(negedge clk); resets += int'(safe_reset | safe_din_valid); end
      total++; if (resets !== 0) $display("FAIL exh_no_wrap got=%0d exp=0", resets); else passed++;
      total++; if (exhausted !== 1'b1) $display("FAIL exh_hold got=%b exp=1", exhausted); else passed++;
   endtask

   task automatic test_gap();
      logic [8:0] tbl [12];
      tbl = '{9'h000, 9'h1BA, 9'h000, 9'h000, 9'h1AD, 9'h000, 9'h000,
              9'h1C0, 9'h000, 9'h000, 9'h1DE, 9'h000};
      lock_code = 32'hBAADC0DE;
      @(negedge clk); seed_g = 32'hBAADC0DE; start_g = 1'b1;
      @(negedge clk); start_g = 1'b0;
      for (int c = 0; c < 12; c++) begin
         total++; if ({safe_din_valid_g, safe_din_g} !== tbl[c])
            $display("FAIL gap_cycle%0d got=%h exp=%h", c + 1, {safe_din_valid_g, safe_din_g}, tbl[c]);
         else passed++;
         @(negedge clk);
      end
      total++; if (found_g !== 1'b1) $display("FAIL gap_found got=%b exp=1", found_g); else passed++;
      total++; if (attempts_g !== 32'd1) $display("FAIL gap_attempts got=%0d exp=1", attempts_g); else passed++;
   endtask

   task automatic test_reset_abort();
      int n;
      start_pulse(32'h11223344);
      repeat (3) @(negedge clk);
      total++; if ({safe_din_valid, safe_din} !== 9'h133)
         $display("FAIL abort_byte2 got=%h exp=133", {safe_din_valid, safe_din}); else passed++;
      reset = 1'b1;
      @(negedge clk);
      total++; if ({safe_din_valid, safe_reset, safe_din, busy, found, exhausted} !== 13'h0)
         $display("FAIL abort_ctrl got=%h exp=0", {safe_din_valid, safe_reset, safe_din, busy, found, exhausted});
      else passed++;
      total++; if ({code, attempts} !== 64'h0)
         $display("FAIL abort_regs got=%h exp=0", {code, attempts}); else passed++;
      reset = 1'b0;
      start_pulse(32'hBAADC0DE);
      n = 1;
      while (!found && n < 40) begin @(negedge clk); n++; end
      total++; if (n !== 7) $display("FAIL abort_restart_latency got=%0d exp=7", n); else passed++;
      total++; if (attempts !== 32'd1) $display("FAIL abort_restart_attempts got=%0d exp=1", attempts); else passed++;
   endtask

   task automatic test_start_busy();
      int n;
      start_pulse(32'hBAADC0DC);
      @(negedge clk); seed = 32'h0; start = 1'b1;
      @(negedge clk); start = 1'b0;
      n = 3;
      while (!found && n < 100) begin @(negedge clk); n++; end
      total++; if (n !== 19) $display("FAIL busy_latency got=%0d exp=19", n); else passed++;
      total++; if (attempts !== 32'd3) $display("FAIL busy_attempts got=%0d exp=3", attempts); else passed++;
      total++; if (code !== 32'hBAADC0DE) $display("FAIL busy_code got=%h exp=baadc0de", code); else passed++;
      start_pulse(32'hBAADC0DE);
      total++; if ({found, busy, code} !== 34'h1_0000_0000)
         $display("FAIL done_restart_clear got=%h exp=100000000", {found, busy, code}); else passed++;
      n = 1;
      while (!found && n < 40) begin @(negedge clk); n++; end
      total++; if (n !== 7) $display("FAIL done_restart_latency got=%0d exp=7", n); else passed++;
      total++; if (attempts !== 32'd1) $display("FAIL done_restart_attempts got=%0d exp=1", attempts); else passed++;
   endtask

   initial begin
      test_reset();
      test_first_hit();
      test_search();
      test_exhaust();
      test_gap();
      test_reset_abort();
      test_start_busy();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
